// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared constants and counter helper for the branch target buffer
// Counter encodings, field widths and the 2-bit saturating update used by bpred_btb.
package bpred_pkg;

   localparam int PC_W  = 32;
   localparam int CTR_W = 2;

   localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
   localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
   localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
   localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

   function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                 input logic             taken);
      logic [CTR_W-1:0] n;
      n = ctr;
      if (taken) begin
         if (ctr != CTR_ST) n = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) n = ctr - 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bpred_fd_reg.sv
// rtl/bpred_fd_reg.sv - fetch-to-decode prediction register
// Async reset, synchronous clear (wins over hold), load enable.
module bpred_fd_reg
   import bpred_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            clr_i,
   input  logic            hit_i,
   input  logic            pred_taken_i,
   input  logic [PC_W-1:0] pred_pc_i,
   output logic            hit_o,
   output logic            pred_taken_o,
   output logic [PC_W-1:0] pred_pc_o
);

   logic            hit_q, hit_d;
   logic            pred_taken_q, pred_taken_d;
   logic [PC_W-1:0] pred_pc_q, pred_pc_d;

   always_comb begin
      hit_d        = hit_q;
      pred_taken_d = pred_taken_q;
      pred_pc_d    = pred_pc_q;
      if (clr_i) begin
         hit_d        = 1'b0;
         pred_taken_d = 1'b0;
         pred_pc_d    = '0;
      end else if (en_i) begin
         hit_d        = hit_i;
         pred_taken_d = pred_taken_i;
         pred_pc_d    = pred_pc_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q        <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_pc_q    <= '0;
      end else begin
         hit_q        <= hit_d;
         pred_taken_q <= pred_taken_d;
         pred_pc_q    <= pred_pc_d;
      end
   end

   assign hit_o        = hit_q;
   assign pred_taken_o = pred_taken_q;
   assign pred_pc_o    = pred_pc_q;

endmodule

// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - direct-mapped BTB with 2-bit counters, lookup in F, resolve/train in D
// Optional statistics counters are built when BPRED_STATS_EN is defined.
module bpred_btb
   import bpred_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 26,
   parameter int STAT_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] PCF,
   output logic            HitF,
   output logic            PredTakenF,
   output logic [PC_W-1:0] PredPCF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic [PC_W-1:0] PCD,
   input  logic            BranchD,
   input  logic            JumpD,
   input  logic            TakenD,
   input  logic [PC_W-1:0] PCBranchD,
   input  logic [PC_W-1:0] PCJumpD,
   output logic            HitD,
   output logic            PredTakenD,
   output logic            RedirectD,
   output logic [PC_W-1:0] RedirectPCD
`ifdef BPRED_STATS_EN
  ,output logic [STAT_W-1:0] LookupCnt
  ,output logic [STAT_W-1:0] MispredCnt
`endif
);

   localparam int ENTRIES = 2**IDX_W;

   if (IDX_W + TAG_W != 30 || STAT_W < 1) begin : g_bad_cfg
      $error("bpred_btb: IDX_W+TAG_W must equal 30 and STAT_W must be positive");
   end

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];
   logic             isjump_q [ENTRIES];

   logic [IDX_W-1:0] idx_f, idx_pcd;
   logic [TAG_W-1:0] tag_f, tag_pcd;
   logic [PC_W-1:0]  pred_pcd, pcd_plus4, act_pc;
   logic             act, act_taken, phantom, tbl_hit_pcd;

   assign idx_f   = PCF[IDX_W+1:2];
   assign tag_f   = PCF[PC_W-1:IDX_W+2];
   assign idx_pcd = PCD[IDX_W+1:2];
   assign tag_pcd = PCD[PC_W-1:IDX_W+2];

   assign HitF       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign PredTakenF = HitF && (isjump_q[idx_f] || ctr_q[idx_f][1]);
   assign PredPCF    = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

   bpred_fd_reg u_fd_reg (
      .clk          (clk),
      .rst_n        (reset),
      .en_i         (~StallD),
      .clr_i        (FlushD),
      .hit_i        (HitF),
      .pred_taken_i (PredTakenF),
      .pred_pc_i    (PredPCF),
      .hit_o        (HitD),
      .pred_taken_o (PredTakenD),
      .pred_pc_o    (pred_pcd)
   );

   // Training hit is taken from the live table at PCD, not the registered HitD.
   assign tbl_hit_pcd = valid_q[idx_pcd] && (tag_q[idx_pcd] == tag_pcd);
   assign pcd_plus4   = PCD + 32'd4;
   assign act         = (BranchD || JumpD) && !StallD;
   assign act_taken   = JumpD || (BranchD && TakenD);
   assign act_pc      = JumpD ? PCJumpD : (act_taken ? PCBranchD : pcd_plus4);
   assign phantom     = !BranchD && !JumpD && PredTakenD && !StallD;
   assign RedirectD   = (act && (act_pc != pred_pcd)) || phantom;
   assign RedirectPCD = !RedirectD ? '0 : (phantom ? pcd_plus4 : act_pc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (!StallD) begin
         if (phantom) valid_q[idx_pcd] <= 1'b0;
         else if (act && (tbl_hit_pcd || act_taken)) valid_q[idx_pcd] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (act) begin
         if (tbl_hit_pcd) begin
            ctr_q[idx_pcd]    <= ctr_next(ctr_q[idx_pcd], act_taken);
            isjump_q[idx_pcd] <= JumpD;
            if (act_taken) target_q[idx_pcd] <= act_pc;
         end else if (act_taken) begin
            tag_q[idx_pcd]    <= tag_pcd;
            target_q[idx_pcd] <= act_pc;
            ctr_q[idx_pcd]    <= CTR_WT;
            isjump_q[idx_pcd] <= JumpD;
         end
      end
   end

`ifdef BPRED_STATS_EN
   logic [STAT_W-1:0] lookup_cnt_q, mispred_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lookup_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         lookup_cnt_q  <= lookup_cnt_q + STAT_W'(act);
         mispred_cnt_q <= mispred_cnt_q + STAT_W'(RedirectD);
      end
   end

   assign LookupCnt  = lookup_cnt_q;
   assign MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_bpred_btb.sv
// tb/tb_bpred_btb.sv - scoreboard bench for bpred_btb (BPRED_STATS_EN optional)
// Driver queues expected outputs per cycle; a negedge monitor pops and compares.
module tb_bpred_btb;

   localparam int S_HITF = 0, S_PTF = 1, S_PPCF = 2, S_HITD = 3, S_PTD = 4;
   localparam int S_RED = 5, S_RPC = 6, S_LCNT = 7, S_MCNT = 8;

   typedef struct {
      string       nm;
      int          cyc;
      int          sel;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF, PCD, PCBranchD, PCJumpD, PredPCF, RedirectPCD;
   logic        HitF, PredTakenF, StallD, FlushD, BranchD, JumpD, TakenD;
   logic        HitD, PredTakenD, RedirectD;
`ifdef BPRED_STATS_EN
   logic [31:0] lookup_cnt, mispred_cnt;
`endif

   exp_t sb_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   bpred_btb #(.IDX_W(4), .TAG_W(26), .STAT_W(32)) dut (
      .clk(clk), .reset(reset), .PCF(PCF), .HitF(HitF), .PredTakenF(PredTakenF),
      .PredPCF(PredPCF), .StallD(StallD), .FlushD(FlushD), .PCD(PCD),
      .BranchD(BranchD), .JumpD(JumpD), .TakenD(TakenD), .PCBranchD(PCBranchD),
      .PCJumpD(PCJumpD), .HitD(HitD), .PredTakenD(PredTakenD),
      .RedirectD(RedirectD), .RedirectPCD(RedirectPCD)
`ifdef BPRED_STATS_EN
     ,.LookupCnt(lookup_cnt), .MispredCnt(mispred_cnt)
`endif
   );

   function automatic logic [31:0] get_sig(input int s);
      case (s)
         S_HITF: return {31'b0, HitF};
         S_PTF:  return {31'b0, PredTakenF};
         S_PPCF: return PredPCF;
         S_HITD: return {31'b0, HitD};
         S_PTD:  return {31'b0, PredTakenD};
         S_RED:  return {31'b0, RedirectD};
         S_RPC:  return RedirectPCD;
`ifdef BPRED_STATS_EN
         S_LCNT: return lookup_cnt;
         S_MCNT: return mispred_cnt;
`endif
         default: return 'x;
      endcase
   endfunction

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         exp_t        e;
         logic [31:0] got;
         e   = sb_q.pop_front();
         got = get_sig(e.sel);
         checks++;
         if (got !== e.val) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", e.nm, e.cyc, got, e.val);
         end
      end
   end

   task automatic chk(input string nm, input int sel, input logic [31:0] val);
      sb_q.push_back('{nm, cyc, sel, val});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic d_idle();
      StallD = 0; FlushD = 0; BranchD = 0; JumpD = 0; TakenD = 0;
   endtask

   task automatic d_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      d_idle();
      PCD = pc; BranchD = 1; TakenD = tk; PCBranchD = tgt;
   endtask

   initial begin
      reset = 0; PCF = 32'h40; PCD = 0; PCBranchD = 0; PCJumpD = 0;
      d_idle();
      tick();
      chk("rst_hitf", S_HITF, 0);          chk("rst_predpcf", S_PPCF, 32'h44);
      chk("rst_hitd", S_HITD, 0);          chk("rst_predtakend", S_PTD, 0);
      chk("rst_redirect", S_RED, 0);       chk("rst_redirectpc", S_RPC, 0);
      tick(); reset = 1;
      tick();
      tick();
      // cold-table taken branch: allocate and redirect
      d_br(32'h40, 1, 32'h80);
      chk("cold_hitf", S_HITF, 0);         chk("cold_redirect", S_RED, 1);
      chk("cold_redirectpc", S_RPC, 32'h80);
      tick(); d_idle();
      chk("alloc_hitf", S_HITF, 1);        chk("alloc_ptf", S_PTF, 1);
      chk("alloc_predpcf", S_PPCF, 32'h80); chk("alloc_noredir", S_RED, 0);
      tick();
      // not-taken twice: 10 -> 01 -> 00
      d_br(32'h40, 0, 32'h80);
      chk("nt1_hitd", S_HITD, 1);          chk("nt1_ptd", S_PTD, 1);
      chk("nt1_redirect", S_RED, 1);       chk("nt1_redirectpc", S_RPC, 32'h44);
      chk("collide_predpcf", S_PPCF, 32'h80);
      tick();
      chk("nt2_ptf", S_PTF, 0);            chk("nt2_predpcf", S_PPCF, 32'h44);
      chk("nt2_redirect", S_RED, 1);       chk("nt2_redirectpc", S_RPC, 32'h44);
      tick(); d_idle();
      chk("nt_hitf", S_HITF, 1);           chk("nt_ptf", S_PTF, 0);
      chk("nt_hitd", S_HITD, 1);           chk("nt_ptd", S_PTD, 0);
      tick();
      d_br(32'h40, 0, 32'h80);
      chk("nt_correct_redir", S_RED, 0);   chk("nt_correct_rpc", S_RPC, 0);
      tick(); d_idle();
      chk("sat_ptf", S_PTF, 0);
      tick();
      // jump at 0x100 overwrites idx 0
      PCF = 32'h100; PCD = 32'h100; JumpD = 1; PCJumpD = 32'h200;
      chk("jmp_hitf", S_HITF, 0);          chk("jmp_predpcf", S_PPCF, 32'h104);
      chk("jmp_redirect", S_RED, 1);       chk("jmp_redirectpc", S_RPC, 32'h200);
      tick(); d_idle(); PCF = 32'h140;
      chk("alias_hitf", S_HITF, 0);        chk("alias_predpcf", S_PPCF, 32'h144);
      tick(); PCF = 32'h100;
      chk("jmp_hitf2", S_HITF, 1);         chk("jmp_ptf2", S_PTF, 1);
      chk("jmp_predpcf2", S_PPCF, 32'h200);
      tick();
      // phantom: predicted-taken non-branch in D
      chk("phantom_redirect", S_RED, 1);   chk("phantom_rpc", S_RPC, 32'h104);
      chk("phantom_oldhit", S_HITF, 1);
      tick(); StallD = 1; FlushD = 1;
      chk("inval_hitf", S_HITF, 0);        chk("inval_predpcf", S_PPCF, 32'h104);
      chk("stall_nophantom", S_RED, 0);
      tick(); FlushD = 0;
      BranchD = 1; TakenD = 1; PCD = 32'h40; PCBranchD = 32'h80; PCF = 32'h40;
      chk("flush_hitd", S_HITD, 0);        chk("flush_ptd", S_PTD, 0);
      chk("stall_redirect", S_RED, 0);     chk("stall_rpc", S_RPC, 0);
      tick();
      d_br(32'h40, 1, 32'h80);
      chk("stall_notrain", S_HITF, 0);     chk("stall_held_hitd", S_HITD, 0);
      chk("retrain_redirect", S_RED, 1);   chk("retrain_rpc", S_RPC, 32'h80);
`ifdef BPRED_STATS_EN
      chk("lookup_cnt", S_LCNT, 5);        chk("mispred_cnt", S_MCNT, 5);
`endif
      tick(); d_idle();
      chk("retrain_hitf", S_HITF, 1);      chk("retrain_predpcf", S_PPCF, 32'h80);
      tick(); reset = 0;
      chk("midrst_hitf", S_HITF, 0);       chk("midrst_predpcf", S_PPCF, 32'h44);
      chk("midrst_hitd", S_HITD, 0);       chk("midrst_redirect", S_RED, 0);
`ifdef BPRED_STATS_EN
      chk("midrst_lcnt", S_LCNT, 0);       chk("midrst_mcnt", S_MCNT, 0);
`endif
      tick(); reset = 1;
      tick();
      chk("postrst_hitf", S_HITF, 0);      chk("postrst_predpcf", S_PPCF, 32'h44);
      tick();
      @(negedge clk); #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
